// File: rtl/opendap_apb_test_slave_pkg.sv
// Shared constants and types for the OpenDAP APB test slave.
//   - register offsets within paddr[11:0]
//   - CTRL field positions
//   - transfer state enum
package opendap_apb_test_slave_pkg;

  localparam logic [11:0] ADDR_CTRL      = 12'h100;
  localparam logic [11:0] ADDR_ACC_COUNT = 12'h104;
  localparam logic [11:0] ADDR_ERR_ADDR  = 12'h108;

  localparam int CTRL_WAIT_LSB    = 0;
  localparam int CTRL_WAIT_W      = 4;
  localparam int CTRL_ERR_INJ_BIT = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/opendap_apb_test_slave.sv
// APB3 test target for the OpenDAP MEM-AP destination port.
// Provides a zero-initialised word RAM, programmable wait states,
// error injection, an access counter and a last-error address register.
// Ports:
//   clk, rst_n            - APB clock, async active-low reset
//   psel, penable, pwrite - APB control
//   paddr[31:0]           - byte address (only [11:0] decoded)
//   pwdata[31:0]          - write data
//   prdata[31:0]          - read data, fixed at setup
//   pready                - high when the wait counter is zero
//   pslverr               - error response, qualified by pready
module opendap_apb_test_slave
  import opendap_apb_test_slave_pkg::*;
#(
  parameter int          RAM_DEPTH_LOG2 = 4,
  parameter logic [3:0]  RESET_WAIT     = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int          DEPTH   = 1 << RAM_DEPTH_LOG2;
  localparam logic [11:0] RAM_END = 12'(DEPTH * 4);

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic [3:0]                  ctrl_wait_q, ctrl_wait_d;
  logic                        ctrl_inj_q, ctrl_inj_d;
  logic [31:0]                 acc_q, acc_d;
  logic [31:0]                 err_addr_q, err_addr_d;
  logic [DEPTH-1:0][31:0]      ram_q, ram_d;

  logic [11:0]                 addr;
  logic [RAM_DEPTH_LOG2-1:0]   ram_idx;
  logic                        hit_ram, hit_ctrl, hit_acc, hit_err_addr;
  logic                        dec_err;
  logic [31:0]                 rd_val;
  logic                        setup, complete;

  assign addr    = paddr[11:0];
  assign ram_idx = addr[RAM_DEPTH_LOG2+1:2];

  assign setup    = (state_q == IDLE) && psel && !penable;
  assign complete = (state_q == ACCESS) && psel && penable && (cnt_q == 4'd0);

  // Address decode and read mux, evaluated against the live APB address
  always_comb begin
    hit_ram      = (addr < RAM_END);
    hit_ctrl     = (addr == ADDR_CTRL);
    hit_acc      = (addr == ADDR_ACC_COUNT);
    hit_err_addr = (addr == ADDR_ERR_ADDR);
    // Injection spares CTRL so software can always turn it back off
    dec_err = (addr[1:0] != 2'b00)
            || !(hit_ram || hit_ctrl || hit_acc || hit_err_addr)
            || (pwrite && hit_err_addr)
            || (ctrl_inj_q && !hit_ctrl);
    rd_val = '0;
    if (hit_ram) begin
      rd_val = ram_q[ram_idx];
    end else if (hit_ctrl) begin
      rd_val[CTRL_WAIT_LSB +: CTRL_WAIT_W] = ctrl_wait_q;
      rd_val[CTRL_ERR_INJ_BIT]             = ctrl_inj_q;
    end else if (hit_acc) begin
      rd_val = acc_q;
    end else if (hit_err_addr) begin
      rd_val = err_addr_q;
    end
  end

  // State register plus all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ctrl_wait_q <= RESET_WAIT;
      ctrl_inj_q  <= 1'b0;
      acc_q       <= '0;
      err_addr_q  <= '0;
      ram_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ctrl_wait_q <= ctrl_wait_d;
      ctrl_inj_q  <= ctrl_inj_d;
      acc_q       <= acc_d;
      err_addr_q  <= err_addr_d;
      ram_q       <= ram_d;
    end
  end

  // Next state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = ctrl_wait_q;
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: drop it silently
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          if (cnt_q == 4'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Setup capture and completion side effects. Completion decodes the
  // target from paddr again, relying on APB holding it stable.
  always_comb begin
    err_d       = err_q;
    rdata_d     = rdata_q;
    ctrl_wait_d = ctrl_wait_q;
    ctrl_inj_d  = ctrl_inj_q;
    acc_d       = acc_q;
    err_addr_d  = err_addr_q;
    ram_d       = ram_q;
    if (setup) begin
      err_d   = dec_err;
      rdata_d = (dec_err || pwrite) ? 32'd0 : rd_val;
    end
    if (complete) begin
      acc_d = (acc_q == 32'hFFFF_FFFF) ? acc_q : acc_q + 32'd1;
      if (err_q) begin
        err_addr_d = paddr;
      end else if (pwrite) begin
        if (hit_ram) ram_d[ram_idx] = pwdata;
        if (hit_ctrl) begin
          ctrl_wait_d = pwdata[CTRL_WAIT_LSB +: CTRL_WAIT_W];
          ctrl_inj_d  = pwdata[CTRL_ERR_INJ_BIT];
        end
        // Clear takes priority over this transfer's own increment
        if (hit_acc) acc_d = '0;
      end
    end
  end

  // Outputs
  always_comb begin
    pready  = (cnt_q == 4'd0);
    pslverr = err_q && pready;
    prdata  = rdata_q;
  end

endmodule

// File: tb/tb_opendap_apb_test_slave.sv
module tb_opendap_apb_test_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  opendap_apb_test_slave dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full APB transfer; inputs change on negedge, outputs sampled on negedge
  task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int cyc);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    cyc = 2;
    for (int i = 0; i < 40 && !pready; i++) begin
      @(negedge clk);
      cyc++;
    end
    if (!pready) chk("timeout", {31'd0, pready}, 32'd1);
    rd = prdata;
    er = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_c);
    logic [31:0] rd; logic er; int cyc;
    apb(1'b0, a, 32'd0, rd, er, cyc);
    chk({tag, ".data"}, rd, exp_d);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_e});
    if (exp_c > 0) chk({tag, ".cyc"}, cyc, exp_c);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_e, input int exp_c);
    logic [31:0] rd; logic er; int cyc;
    apb(1'b1, a, wd, rd, er, cyc);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_e});
    if (exp_c > 0) chk({tag, ".cyc"}, cyc, exp_c);
  endtask

  initial begin
    rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    repeat (3) @(negedge clk);
    chk("rst.pready", {31'd0, pready}, 32'd1);
    chk("rst.pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst.prdata", prdata, 32'd0);
    rst_n = 1'b1;

    // Access counter starts at zero and excludes the current transfer
    rd_chk("acc0", 32'h104, 32'd0, 1'b0, 2);
    rd_chk("acc1", 32'h104, 32'd1, 1'b0, 2);

    // RAM storage
    wr_chk("wr00c", 32'h00C, 32'hCAFEF00D, 1'b0, 2);
    for (int i = 0; i < 16; i++)
      rd_chk($sformatf("ram%0d", i), 32'(i * 4), (i == 3) ? 32'hCAFEF00D : 32'd0, 1'b0, 2);

    // Wait states: the CTRL write itself is still 2 cycles
    wr_chk("ctrl3", 32'h100, 32'h3, 1'b0, 2);
    rd_chk("rdw3", 32'h000, 32'd0, 1'b0, 5);
    rd_chk("ctrlrd", 32'h100, 32'h3, 1'b0, 5);
    wr_chk("ctrl0", 32'h100, 32'h0, 1'b0, 5);

    // Error decode
    rd_chk("misal", 32'h002, 32'd0, 1'b1, 2);
    rd_chk("undec", 32'h200, 32'd0, 1'b1, 2);
    rd_chk("erraddr", 32'h108, 32'h200, 1'b0, 2);
    wr_chk("wrerra", 32'h108, 32'hFFFF_FFFF, 1'b1, 2);
    rd_chk("erraddr2", 32'h108, 32'h108, 1'b0, 2);
    wr_chk("misalwr", 32'h00E, 32'h1, 1'b1, 2);
    rd_chk("ramkeep", 32'h00C, 32'hCAFEF00D, 1'b0, 2);
    rd_chk("hiaddr", 32'hABCD_0300, 32'd0, 1'b1, 2);
    rd_chk("erraddr3", 32'h108, 32'hABCD_0300, 1'b0, 2);

    // Error injection spares CTRL
    wr_chk("inj_on", 32'h100, 32'h100, 1'b0, 2);
    wr_chk("injwr", 32'h004, 32'h12345678, 1'b1, 2);
    rd_chk("injctrl", 32'h100, 32'h100, 1'b0, 2);
    wr_chk("inj_off", 32'h100, 32'h0, 1'b0, 2);
    rd_chk("ram1keep", 32'h004, 32'd0, 1'b0, 2);
    wr_chk("wr004", 32'h004, 32'h55AA, 1'b0, 2);
    rd_chk("rd004", 32'h004, 32'h55AA, 1'b0, 2);

    // Clear wins over the increment of the clearing write
    wr_chk("accclr", 32'h104, 32'h1234, 1'b0, 2);
    rd_chk("acc_a", 32'h104, 32'd0, 1'b0, 2);
    rd_chk("acc_b", 32'h104, 32'd1, 1'b0, 2);

    // Async reset during a stall
    wr_chk("ctrl5", 32'h100, 32'h5, 1'b0, 2);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h00C;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("stall.pready", {31'd0, pready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst.pready", {31'd0, pready}, 32'd1);
    chk("arst.pslverr", {31'd0, pslverr}, 32'd0);
    chk("arst.prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("postctrl", 32'h100, 32'h0, 1'b0, 2);
    rd_chk("postram", 32'h00C, 32'd0, 1'b0, 2);
    rd_chk("posterra", 32'h108, 32'd0, 1'b0, 2);
    rd_chk("postacc", 32'h104, 32'd3, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
